// File: rtl/stack_call_controller_pkg.sv
// Shared state encoding and sizing helper for the subroutine call-stack controller.
package cpu_stack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUSH    = 2'd1,
    ST_POP     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1 (callers pass depth+1 to size depth_count).
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stack_call_controller_if.sv
// Request, LIFO and program-counter signals of the call-stack controller.
interface stack_call_controller_if
  import cpu_stack_pkg::*;
#(
  parameter int width        = 16,
  parameter int depth        = 16,
  parameter int log2_depthp1 = log2_ceil(depth + 1)
);

  logic                    call_req;
  logic                    ret_req;
  logic [width-1:0]        ret_addr;
  logic                    stk_push;
  logic                    stk_pop;
  logic [width-1:0]        stk_data;
  logic [width-1:0]        stk_q;
  logic                    pc_load;
  logic [width-1:0]        pc_value;
  logic                    busy;
  logic [log2_depthp1-1:0] depth_count;
  logic                    overflow;
  logic                    underflow;
  logic                    req_dropped;

  // Controller side
  modport master (
    input  call_req, ret_req, ret_addr, stk_q,
    output stk_push, stk_pop, stk_data, pc_load, pc_value, busy,
           depth_count, overflow, underflow, req_dropped
  );

  // Requester / LIFO side
  modport slave (
    output call_req, ret_req, ret_addr, stk_q,
    input  stk_push, stk_pop, stk_data, pc_load, pc_value, busy,
           depth_count, overflow, underflow, req_dropped
  );

endinterface

// File: rtl/stack_call_controller.sv
// Sequences subroutine call/return requests onto an external LIFO and
// returns popped addresses to the program counter.
module stack_call_controller
  import cpu_stack_pkg::*;
#(
  parameter int width        = 16,
  parameter int depth        = 16,
  parameter int log2_depthp1 = log2_ceil(depth + 1)
) (
  input logic                    i_clock,
  input logic                    i_reset,
  stack_call_controller_if.master bus
);

  // state      | meaning
  // ST_IDLE    | waiting for call_req / ret_req
  // ST_PUSH    | strobing latched return address into the LIFO
  // ST_POP     | strobing a pop from the LIFO
  // ST_CAPTURE | registering LIFO output into pc_value

  localparam logic [log2_depthp1-1:0] CNT_FULL = log2_depthp1'(depth);
  localparam logic [log2_depthp1-1:0] CNT_ONE  = log2_depthp1'(1);

  state_t                  r_state;
  logic [width-1:0]        r_data;
  logic [width-1:0]        r_pc_value;
  logic                    r_pc_load;
  logic [log2_depthp1-1:0] r_count;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    r_req_dropped;

  state_t w_state_nxt;
  logic   w_latch;
  logic   w_push;
  logic   w_pop;
  logic   w_set_ovf;
  logic   w_set_udf;
  logic   w_set_drop;
  logic   w_any_req;

  assign w_any_req = bus.call_req | bus.ret_req;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_data        <= '0;
      r_pc_value    <= '0;
      r_pc_load     <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_req_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc_load <= (r_state == ST_CAPTURE);
      if (w_latch) r_data <= bus.ret_addr;
      if (r_state == ST_CAPTURE) r_pc_value <= bus.stk_q;
      if (w_push) r_count <= r_count + CNT_ONE;
      else if (w_pop) r_count <= r_count - CNT_ONE;
      if (w_set_ovf) r_overflow <= 1'b1;
      if (w_set_udf) r_underflow <= 1'b1;
      if (w_set_drop) r_req_dropped <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_udf   = 1'b0;
    w_set_drop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.call_req) begin
          // A simultaneous return loses to the call and is flagged.
          w_set_drop = bus.ret_req;
          if (r_count == CNT_FULL) begin
            w_set_ovf = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_PUSH;
          end
        end else if (bus.ret_req) begin
          if (r_count == '0) w_set_udf = 1'b1;
          else w_state_nxt = ST_POP;
        end
      end
      ST_PUSH: begin
        w_push      = 1'b1;
        w_set_drop  = w_any_req;
        w_state_nxt = ST_IDLE;
      end
      ST_POP: begin
        w_pop       = 1'b1;
        w_set_drop  = w_any_req;
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_set_drop  = w_any_req;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.stk_push    = w_push;
  assign bus.stk_pop     = w_pop;
  assign bus.stk_data    = r_data;
  assign bus.pc_load     = r_pc_load;
  assign bus.pc_value    = r_pc_value;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.depth_count = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.req_dropped = r_req_dropped;

endmodule
